// File: rtl/tx_sr_pkg.sv
// Shared types and constants for the SDA transmit shift-register controller.
package tx_sr_pkg;

    // Controller states; ST_ACK is only reachable when TX_SR_ACK_CHECK_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ACK   = 2'd2,
        ST_DONE  = 2'd3
    } tx_sr_state_e;

    // Value driven on SDA whenever the transmitter is not presenting a data bit.
    localparam logic SDA_IDLE = 1'b1;

endpackage

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register with 1-fill. Load has priority over shift.
// SHIFT_MSB=1 shifts left and presents the MSB; SHIFT_MSB=0 shifts right and presents the LSB.
module flex_pts_sr #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                load_enable,
    input  logic [NUM_BITS-1:0] parallel_in,
    output logic                serial_out
);

    logic [NUM_BITS-1:0] sr;

    // Register holds all ones out of reset so the serial output reads as released.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr <= '1;
        end else if (load_enable) begin
            sr <= parallel_in;
        end else if (shift_enable) begin
            if (SHIFT_MSB) begin
                sr <= {sr[NUM_BITS-2:0], 1'b1};
            end else begin
                sr <= {1'b1, sr[NUM_BITS-1:1]};
            end
        end
    end

    assign serial_out = SHIFT_MSB ? sr[NUM_BITS-1] : sr[0];

endmodule

// File: rtl/tx_sr_ctrl.sv
// Byte transmitter for an I2C-style slave: shifts a byte out on SDA, MSB first,
// advancing on SCL falling edges, then optionally samples the master ACK.
// Optional feature macro: TX_SR_ACK_CHECK_EN (adds the ACK state and ack/nack pulses).
//
// Handshake: load_data is a single-cycle request accepted only in IDLE; a request
// seen in any other state is dropped, not queued. byte_done, ack_rcvd and
// nack_rcvd are single-cycle pulses with no back-pressure. stop_found overrides
// everything and returns the controller to IDLE on the next edge.
module tx_sr_ctrl
    import tx_sr_pkg::*;
#(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                load_data,
    input  logic                tx_enable,
    input  logic                falling_edge_found,
    input  logic                rising_edge_found,
    input  logic                stop_found,
    input  logic                sda_in,
    output logic                sda_out,
    output logic                tx_busy,
    output logic                byte_done,
    output logic                ack_rcvd,
    output logic                nack_rcvd,
    output tx_sr_state_e        state_dbg
);

    localparam int CNT_W = $clog2(NUM_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

    tx_sr_state_e     state;
    tx_sr_state_e     next_state;
    logic [CNT_W-1:0] bit_cnt;
    logic             load_en;
    logic             shift_en;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             serial_bit;

`ifndef TX_SR_ACK_CHECK_EN
    // Without ACK checking the master response line has no consumer.
    logic unused_sda_in;
    assign unused_sda_in = sda_in;
`endif

    flex_pts_sr #(
        .NUM_BITS  (NUM_BITS),
        .SHIFT_MSB (1'b1)
    ) u_pts_sr (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (shift_en),
        .load_enable  (load_en),
        .parallel_in  (tx_data),
        .serial_out   (serial_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Bit counter: cleared on load, bumped on every non-final shift, so it never wraps.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt <= '0;
        end else if (cnt_clr) begin
            bit_cnt <= '0;
        end else if (cnt_inc) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Next-state decode and output pulses; STOP is applied last so it wins over everything.
    always_comb begin
        next_state = state;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        sda_out    = SDA_IDLE;
        byte_done  = 1'b0;
        ack_rcvd   = 1'b0;
        nack_rcvd  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (load_data) begin
                    next_state = ST_SHIFT;
                    load_en    = 1'b1;
                    cnt_clr    = 1'b1;
                end
            end
            ST_SHIFT: begin
                sda_out = serial_bit;
                if (falling_edge_found && tx_enable) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef TX_SR_ACK_CHECK_EN
                        next_state = ST_ACK;
`else
                        next_state = ST_DONE;
`endif
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
`ifdef TX_SR_ACK_CHECK_EN
            ST_ACK: begin
                if (rising_edge_found && tx_enable) begin
                    next_state = ST_DONE;
                    if (sda_in) begin
                        nack_rcvd = 1'b1;
                    end else begin
                        ack_rcvd = 1'b1;
                    end
                end
            end
`endif
            ST_DONE: begin
                byte_done  = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        if (stop_found) begin
            next_state = ST_IDLE;
            load_en    = 1'b0;
            shift_en   = 1'b0;
            cnt_clr    = 1'b0;
            cnt_inc    = 1'b0;
            byte_done  = 1'b0;
            ack_rcvd   = 1'b0;
            nack_rcvd  = 1'b0;
        end
    end

    assign tx_busy   = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_tx_sr_ctrl.sv
// Bench for tx_sr_ctrl: scoreboard of expected SDA bits, pushed at load, popped per bit.
module tb_tx_sr_ctrl;
    import tx_sr_pkg::*;

    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [NB-1:0] tx_data = '0;
    logic          load_data = 1'b0;
    logic          tx_enable = 1'b1;
    logic          falling_edge_found = 1'b0;
    logic          rising_edge_found = 1'b0;
    logic          stop_found = 1'b0;
    logic          sda_in = 1'b1;
    logic          sda_out;
    logic          tx_busy;
    logic          byte_done;
    logic          ack_rcvd;
    logic          nack_rcvd;
    tx_sr_state_e  state_dbg;

    int total = 0;
    int bad = 0;
    logic [0:0] exp_q[$];

    tx_sr_ctrl #(.NUM_BITS(NB)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .tx_data            (tx_data),
        .load_data          (load_data),
        .tx_enable          (tx_enable),
        .falling_edge_found (falling_edge_found),
        .rising_edge_found  (rising_edge_found),
        .stop_found         (stop_found),
        .sda_in             (sda_in),
        .sda_out            (sda_out),
        .tx_busy            (tx_busy),
        .byte_done          (byte_done),
        .ack_rcvd           (ack_rcvd),
        .nack_rcvd          (nack_rcvd),
        .state_dbg          (state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [NB-1:0] b);
        tx_data   = b;
        load_data = 1'b1;
        tick();
        load_data = 1'b0;
        tx_data   = ~b;
        for (int i = NB - 1; i >= 0; i--) exp_q.push_back(b[i]);
        check("busy_after_load", 32'(tx_busy), 1);
    endtask

    task automatic send_bits(input int n);
        logic [0:0] e;
        for (int i = 0; i < n; i++) begin
            check("sb_queue_nonempty", 32'(exp_q.size() != 0), 1);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b1;
            check("sda_bit", 32'(sda_out), 32'(e));
            tx_enable          = 1'b1;
            falling_edge_found = 1'b1;
            tick();
            falling_edge_found = 1'b0;
        end
    endtask

    task automatic finish_byte(input logic ack_in);
`ifdef TX_SR_ACK_CHECK_EN
        check("ack_sda_release", 32'(sda_out), 1);
        check("ack_busy", 32'(tx_busy), 1);
        sda_in            = ack_in;
        rising_edge_found = 1'b1;
        #1;
        check("ack_rcvd", 32'(ack_rcvd), 32'(!ack_in));
        check("nack_rcvd", 32'(nack_rcvd), 32'(ack_in));
        check("no_done_in_ack", 32'(byte_done), 0);
        tick();
        rising_edge_found = 1'b0;
        sda_in            = 1'b1;
        #1;
`else
        check("ack_tied_low", 32'(ack_rcvd), 0);
        check("nack_tied_low", 32'(nack_rcvd), 0);
`endif
        check("byte_done", 32'(byte_done), 1);
        check("done_busy", 32'(tx_busy), 1);
        load_data = 1'b1;
        tx_data   = 8'h77;
        tick();
        load_data = 1'b0;
        check("byte_done_once", 32'(byte_done), 0);
        check("idle_after_done", 32'(tx_busy), 0);
        check("idle_sda", 32'(sda_out), 1);
    endtask

    initial begin
        logic [NB-1:0] rb;

        // Reset values.
        #2;
        check("rst_busy", 32'(tx_busy), 0);
        check("rst_sda", 32'(sda_out), 1);
        check("rst_done", 32'(byte_done), 0);
        check("rst_ack", 32'(ack_rcvd), 0);
        check("rst_nack", 32'(nack_rcvd), 0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();

        // A5 with ACK.
        load_byte(8'hA5);
        send_bits(NB);
        finish_byte(1'b0);

        // 3C with NACK; rising edge in SHIFT is ignored.
        load_byte(8'h3C);
        rising_edge_found = 1'b1;
        tick();
        rising_edge_found = 1'b0;
        check("rise_in_shift", 32'(sda_out), 32'(exp_q[0]));
        send_bits(NB);
`ifdef TX_SR_ACK_CHECK_EN
        falling_edge_found = 1'b1;
        tick();
        falling_edge_found = 1'b0;
        check("fall_in_ack", 32'(state_dbg), 32'(ST_ACK));
`endif
        finish_byte(1'b1);

        // STOP mid-byte, then 00 sends zeros.
        load_byte(8'hFF);
        send_bits(3);
        stop_found = 1'b1;
        #1;
        check("stop_no_done", 32'(byte_done), 0);
        tick();
        stop_found = 1'b0;
        check("stop_idle", 32'(tx_busy), 0);
        check("stop_sda", 32'(sda_out), 1);
        check("stop_done_after", 32'(byte_done), 0);
        exp_q.delete();
        load_byte(8'h00);
        send_bits(NB);
        finish_byte(1'b0);

        // tx_enable low freezes progress; load while busy is dropped.
        load_byte(8'hC9);
        send_bits(3);
        tx_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            falling_edge_found = 1'b1;
            tick();
            falling_edge_found = 1'b0;
            tick();
        end
        check("frozen_bit", 32'(sda_out), 32'(exp_q[0]));
        check("frozen_state", 32'(state_dbg), 32'(ST_SHIFT));
        tx_data   = 8'h12;
        load_data = 1'b1;
        tick();
        load_data = 1'b0;
        send_bits(NB - 3);
        finish_byte(1'b0);

        // Random bytes and responses.
        for (int k = 0; k < 4; k++) begin
            rb = NB'($urandom_range(0, 255));
            load_byte(rb);
            send_bits(NB);
            finish_byte(1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-SHIFT.
        load_byte(8'h0F);
        send_bits(2);
        check("pre_rst_sda", 32'(sda_out), 0);
        #3;
        n_rst = 1'b0;
        #1;
        check("arst_busy", 32'(tx_busy), 0);
        check("arst_sda", 32'(sda_out), 1);
        check("arst_done", 32'(byte_done), 0);
        check("arst_ack", 32'(ack_rcvd), 0);
        check("arst_nack", 32'(nack_rcvd), 0);
        exp_q.delete();
        @(negedge clk);
        n_rst = 1'b1;
        tick();

        // Recovery after reset.
        load_byte(8'hA5);
        send_bits(NB);
        finish_byte(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
